// File: rtl/mio_pkg.sv
// mio_pkg
// Shared definitions for the memory/IO bus controller:
//   - state_t    : controller FSM states
//   - target_t   : address-decode result
//   - GPIO_ADDR / COUNTER_ADDR : memory-mapped register addresses
//   - decodeTarget() : maps a CPU byte address onto a target
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM,
    TGT_GPIO,
    TGT_COUNTER,
    TGT_UNMAPPED
  } target_t;

  localparam logic [31:0] GPIO_ADDR    = 32'hF000_0000;
  localparam logic [31:0] COUNTER_ADDR = 32'hF000_0004;

  // RAM occupies byte addresses 0 .. 4*2^ramAw-1, so every bit above
  // ramAw+1 must be zero. The two byte-select bits never take part in decode.
  function automatic target_t decodeTarget(input logic [31:0] a,
                                           input int unsigned ramAw,
                                           input logic        counterEn);
    target_t t;
    t = TGT_UNMAPPED;
    if ((a >> (ramAw + 2)) == 32'd0)
      t = TGT_RAM;
    else if ((a & ~32'h3) == GPIO_ADDR)
      t = TGT_GPIO;
    else if (counterEn && ((a & ~32'h3) == COUNTER_ADDR))
      t = TGT_COUNTER;
    return t;
  endfunction

endpackage

// File: rtl/mio_timer.sv
// mio_timer
// 32-bit free-running cycle counter with a synchronous load. A load takes
// priority over the increment in the same cycle; the count wraps naturally.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (count -> 0)
//   i_load      : load strobe
//   i_loadVal   : value loaded when i_load is high
//   o_count     : current count
module mio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_loadVal,
  output logic [31:0] o_count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      o_count <= 32'd0;
    else if (i_load)
      o_count <= i_loadVal;
    else
      o_count <= o_count + 32'd1;
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl
// Bus controller between a CPU request port and a synchronous RAM, a GPIO
// register pair and (optionally) a free-running counter.
//
// Build option: define MIO_COUNTER_EN to place the counter at 0xF000_0004.
// Without it that address is unmapped.
//
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   req, mem_w         : access request (level) and write flag, sampled in IDLE
//   addr               : CPU byte address (word accesses, addr[1:0] ignored)
//   data_from_cpu      : write data
//   data2CPU           : registered read data, valid while MIO_ready is high
//   MIO_ready          : one-cycle completion pulse
//   ram_addr/ram_we/ram_din/ram_dout : synchronous RAM port (1-cycle read)
//   gpio_in / gpio_out : switch inputs / LED register
//   bus_err            : sticky flag, set by any unmapped access
//
// Timing, counting the req-sampling edge as edge 0: non-RAM targets complete
// at edge 0 (MIO_ready high in the following cycle). RAM accesses present the
// address during the first ACCESS cycle, give the RAM its read-latency cycle in
// the second ACCESS cycle, then spend RAM_WAIT cycles in WAIT, so DONE is
// entered at edge 2+RAM_WAIT.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int RAM_WAIT = 2,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_from_cpu,
  output logic [31:0]       data2CPU,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [31:0]       gpio_in,
  output logic [31:0]       gpio_out,
  output logic              bus_err
);

  localparam logic [3:0] WAIT_LOAD = 4'(RAM_WAIT - 1);

`ifdef MIO_COUNTER_EN
  localparam logic COUNTER_EN = 1'b1;
`else
  localparam logic COUNTER_EN = 1'b0;
`endif

  state_t      r_state;
  logic        r_reqWe;
  logic        r_accPhase;
  logic [3:0]  r_waitCnt;
  target_t     w_target;
  logic [31:0] w_count;

  assign w_target = decodeTarget(addr, RAM_AW, COUNTER_EN);

`ifdef MIO_COUNTER_EN
  logic w_counterLoad;

  // A counter write lands on the same edge that samples the request.
  assign w_counterLoad = (r_state == ST_IDLE) && req && mem_w &&
                         (w_target == TGT_COUNTER);

  mio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_counterLoad),
    .i_loadVal(data_from_cpu),
    .o_count  (w_count)
  );
`else
  assign w_count = 32'd0;
`endif

  // Controller FSM. ram_addr/ram_din double as the latched request address
  // and data for RAM accesses; other targets finish on the sampling edge and
  // need nothing latched beyond the write flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_reqWe    <= 1'b0;
      r_accPhase <= 1'b0;
      r_waitCnt  <= 4'd0;
      MIO_ready  <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= 32'd0;
      data2CPU   <= 32'd0;
      gpio_out   <= 32'd0;
      bus_err    <= 1'b0;
    end else begin
      MIO_ready <= 1'b0;
      ram_we    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_reqWe <= mem_w;
            case (w_target)
              TGT_RAM: begin
                ram_addr   <= addr[RAM_AW+1:2];
                ram_din    <= data_from_cpu;
                ram_we     <= mem_w;
                r_accPhase <= 1'b0;
                r_state    <= ST_ACCESS;
              end
              TGT_GPIO: begin
                if (mem_w)
                  gpio_out <= data_from_cpu;
                data2CPU  <= mem_w ? 32'd0 : gpio_in;
                MIO_ready <= 1'b1;
                r_state   <= ST_DONE;
              end
              TGT_COUNTER: begin
                data2CPU  <= mem_w ? 32'd0 : w_count;
                MIO_ready <= 1'b1;
                r_state   <= ST_DONE;
              end
              default: begin
                data2CPU  <= 32'd0;
                bus_err   <= 1'b1;
                MIO_ready <= 1'b1;
                r_state   <= ST_DONE;
              end
            endcase
          end
        end
        // Phase 0: address/strobe on the RAM port. Phase 1: RAM read latency.
        ST_ACCESS: begin
          if (!r_accPhase) begin
            r_accPhase <= 1'b1;
          end else if (RAM_WAIT == 0) begin
            data2CPU  <= r_reqWe ? 32'd0 : ram_dout;
            MIO_ready <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_waitCnt <= WAIT_LOAD;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_waitCnt == 4'd0) begin
            data2CPU  <= r_reqWe ? 32'd0 : ram_dout;
            MIO_ready <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mio_bus_ctrl.md
MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

Interface
REQ-001 Parameter RAM_WAIT, default 2, number of wait cycles inserted per RAM access (legal 0..15).
REQ-002 Parameter RAM_AW, default 10, RAM word-address width.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  CPU access request, level; sampled only in IDLE.
REQ-006 mem_w  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  32  CPU byte address; addr[1:0] ignored, word accesses only.
REQ-008 data_from_cpu  input  32  write data; sampled with req.
REQ-009 data2CPU  output  32  registered read data; valid while MIO_ready=1.
REQ-010 MIO_ready  output  1  one-cycle completion pulse.
REQ-011 ram_addr  output  RAM_AW  synchronous RAM word address.
REQ-012 ram_we  output  1  RAM write strobe.
REQ-013 ram_din  output  32  RAM write data.
REQ-014 ram_dout  input  32  RAM read data, one-cycle latency after ram_addr.
REQ-015 gpio_in  input  32  switch inputs.
REQ-016 gpio_out  output  32  LED register.
REQ-017 bus_err  output  1  sticky unmapped-access flag.

Function
REQ-018 Address map: 0x0000_0000..(4*2^RAM_AW-1) RAM; 0xF000_0000 GPIO; 0xF000_0004 counter; everything else unmapped.
REQ-019 FSM states IDLE, ACCESS, WAIT, DONE; IDLE with req=1 latches mem_w, addr, data_from_cpu into request registers.
REQ-020 RAM target: IDLE->ACCESS; ACCESS drives ram_addr=addr[RAM_AW+1:2], ram_we=mem_w for exactly one cycle, ram_din=latched data.
REQ-021 ACCESS->WAIT if RAM_WAIT>0, WAIT counts RAM_WAIT cycles then ->DONE; ACCESS->DONE if RAM_WAIT=0.
REQ-022 RAM read: data2CPU loaded from ram_dout on entry to DONE; MIO_ready rises 2+RAM_WAIT cycles after the req-sampling edge.
REQ-023 GPIO/counter/unmapped targets: IDLE->DONE directly; MIO_ready high the cycle after sampling.
REQ-024 GPIO read returns gpio_in; GPIO write loads gpio_out on the sampling edge.
REQ-025 Counter: 32-bit free-running +1 per cycle, wraps 0xFFFF_FFFF->0; read returns value at sampling edge; write loads data_from_cpu and write wins over increment that cycle.
REQ-026 Unmapped read returns 0; unmapped write ignored; either sets bus_err=1 until reset.
REQ-027 DONE->IDLE unconditionally; MIO_ready high only in DONE; data2CPU=0 on completed writes.
REQ-028 req deassertion after sampling does not abort; transaction completes.
REQ-029 req still high in IDLE after DONE is a new transaction; requester drops req the cycle after MIO_ready.

Reset
REQ-030 Reset forces IDLE, MIO_ready=0, ram_we=0, ram_addr=0, ram_din=0, data2CPU=0, gpio_out=0, counter=0, bus_err=0, wait counter=0.
REQ-031 Reset mid-transaction abandons it with no MIO_ready pulse and no further ram_we.

Configuration
REQ-032 Macro MIO_COUNTER_EN: defined -> counter present at 0xF000_0004; undefined -> counter logic absent and 0xF000_0004 unmapped (read 0, bus_err set).

Structure
REQ-033 Package mio_pkg holds FSM state encoding, GPIO/counter address constants, address-decode target enumeration.
REQ-034 One sub-module mio_timer (counter with load), instantiated only under MIO_COUNTER_EN.

Verification
REQ-035 Reset, RAM write addr=0x10 data=0xDEADBEEF, RAM_WAIT=2 -> ram_we one cycle with ram_addr=4; MIO_ready 4 cycles after sampling.
REQ-036 RAM read addr=0x10 after REQ-035 -> data2CPU=0xDEADBEEF with MIO_ready 4 cycles after sampling; repeat with RAM_WAIT=0 -> 2 cycles.
REQ-037 gpio_in=0x0000_00A5, read 0xF000_0000 -> data2CPU=0xA5 next cycle; write 0x3C -> gpio_out=0x3C.
REQ-038 Write counter 0xFFFF_FFFE, read 3 cycles later -> wrap observed (value 0x0000_0000 or 0x0000_0001 per sampling edge); without MIO_COUNTER_EN -> read 0, bus_err=1.
REQ-039 Read 0x8000_0000 -> data2CPU=0, bus_err=1, stays 1 across later good accesses until reset.
REQ-040 Assert reset during WAIT -> MIO_ready never pulses, state IDLE, all outputs at reset values.
